apb4_mem_slave: RTL and testbench



---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb4_mem_ram.sv | 53 +++++
 rtl/apb4_mem_slave.sv | 172 +++++++++++++++++
 tb/tb_apb4_mem_slave.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types for the APB4 memory slave: FSM states and error causes.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      WAIT   = 2'd2,
      ACCESS = 2'd3
   } apb4_state_t;

   typedef enum logic [2:0] {
      ERR_NONE  = 3'd0,
      ERR_RANGE = 3'd1,
      ERR_ALIGN = 3'd2,
      ERR_DATA  = 3'd3,
      ERR_PROT  = 3'd4
   } apb4_err_e;

   localparam int CNT_W = 4;

endpackage

// File: rtl/apb4_mem_ram.sv
// Single-port word RAM with byte-enable write and combinational read.
// Simulation builds preload word i with the value i.
module apb4_mem_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 1024,
   localparam int NB = DATA_WIDTH / 8,
   localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         addr,
   input  logic [NB-1:0]         be,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   typedef logic [DATA_WIDTH-1:0] mem_t [MEM_DEPTH];

   function automatic mem_t mem_init();
      mem_t m;
      for (int i = 0; i < MEM_DEPTH; i++) begin
         m[i] = DATA_WIDTH'(i);
      end
      return m;
   endfunction

`ifdef SYNTHESIS
   mem_t mem_q;
`else
   mem_t mem_q = mem_init();
`endif

   logic [DATA_WIDTH-1:0] wmerge;

   // Merge enabled lanes into the current word so the array sees one write
   always_comb begin
      wmerge = mem_q[addr];
      for (int b = 0; b < NB; b++) begin
         if (be[b]) begin
            wmerge[8*b +: 8] = wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wmerge;
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 memory slave with configurable wait states and error decode.
// Define APB_PROT_CHECK_EN to reject non-secure accesses to the low region.
module apb4_mem_slave
   import apb_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int MEM_DEPTH    = 1024,
   parameter int WAIT_STATES  = 0,
   parameter int SECURE_WORDS = 64
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   input  logic [2:0]              PPROT,
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR
);

   localparam int NB  = DATA_WIDTH / 8;
   localparam int BSH = (NB > 1) ? $clog2(NB) : 0;
   localparam int RAW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   apb4_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic write_q, write_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [NB-1:0] strb_q, strb_d;
   logic pready_q, pready_d;

   logic [ADDR_WIDTH-1:0] word_idx;
   logic [DATA_WIDTH-1:0] ram_rdata;
   apb4_err_e err;
   logic bus_acc;
   logic in_acc;
   logic mem_we;

`ifdef APB_PROT_CHECK_EN
   logic nsec_q, nsec_d;
   logic unused_prot;
   assign unused_prot = PPROT[2] ^ PPROT[0];
`else
   logic unused_prot;
   assign unused_prot = (^PPROT) ^ (SECURE_WORDS > 0);
`endif

   assign word_idx = addr_q >> BSH;
   assign bus_acc  = PSEL && PENABLE;
   assign in_acc   = (state_q == ACCESS);

   // Error decode works only on the copies latched at setup
   always_comb begin
      err = ERR_NONE;
      if (word_idx >= ADDR_WIDTH'(MEM_DEPTH)) begin
         err = ERR_RANGE;
      end else if ((addr_q & ADDR_WIDTH'(NB - 1)) != '0) begin
         err = ERR_ALIGN;
`ifndef SYNTHESIS
      end else if (write_q && $isunknown(wdata_q)) begin
         err = ERR_DATA;
`endif
`ifdef APB_PROT_CHECK_EN
      end else if (nsec_q &&
                   (word_idx < ADDR_WIDTH'(SECURE_WORDS))) begin
         err = ERR_PROT;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
`ifdef APB_PROT_CHECK_EN
      nsec_d  = nsec_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               addr_d  = PADDR;
               write_d = PWRITE;
               wdata_d = PWDATA;
               strb_d  = PSTRB;
`ifdef APB_PROT_CHECK_EN
               nsec_d  = PPROT[1];
`endif
               cnt_d   = CNT_W'(WAIT_STATES);
               // Zero-wait slaves answer in the first PENABLE cycle
               state_d = (WAIT_STATES == 0) ? ACCESS : SETUP;
            end
         end
         SETUP, WAIT: begin
            if (!bus_acc) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q - 1'b1;
               state_d = (cnt_d == '0) ? ACCESS : WAIT;
            end
         end
         ACCESS: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      pready_d = (state_d == ACCESS);
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         strb_q   <= '0;
         pready_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         wdata_q  <= wdata_d;
         strb_q   <= strb_d;
         pready_q <= pready_d;
      end
   end

`ifdef APB_PROT_CHECK_EN
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         nsec_q <= 1'b0;
      end else begin
         nsec_q <= nsec_d;
      end
   end
`endif

   assign mem_we = in_acc && bus_acc && write_q && (err == ERR_NONE);

   apb4_mem_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH)
   ) u_ram (
      .clk   (PCLK),
      .we    (mem_we),
      .addr  (word_idx[RAW-1:0]),
      .be    (strb_q),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   assign PREADY  = pready_q;
   assign PSLVERR = in_acc && (err != ERR_NONE);
   assign PRDATA  = (in_acc && !write_q && (err == ERR_NONE)) ?
                    ram_rdata : '0;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Directed bench for apb4_mem_slave: a zero-wait and a 3-wait instance.
// Honours APB_PROT_CHECK_EN for the protection expectations.
module tb_apb4_mem_slave;

`ifdef APB_PROT_CHECK_EN
   localparam bit PROT_EN = 1'b1;
`else
   localparam bit PROT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic psel0, psel3, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [3:0] pstrb;
   logic [2:0] pprot;
   logic [31:0] prdata0, prdata3;
   logic pready0, pready3, pslverr0, pslverr3;

   int tests = 0;
   int fails = 0;
   int cyc_cnt = 0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   apb4_mem_slave #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(1024),
      .WAIT_STATES(0), .SECURE_WORDS(64)
   ) dut0 (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(psel0), .PENABLE(penable),
      .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
      .PPROT(pprot), .PRDATA(prdata0), .PREADY(pready0),
      .PSLVERR(pslverr0)
   );

   apb4_mem_slave #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(1024),
      .WAIT_STATES(3), .SECURE_WORDS(64)
   ) dut3 (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(psel3), .PENABLE(penable),
      .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
      .PPROT(pprot), .PRDATA(prdata3), .PREADY(pready3),
      .PSLVERR(pslverr3)
   );

   // Drives setup then access; returns once PREADY is seen, leaving the
   // bus in access so the next call can follow with no idle cycle.
   task automatic xfer(input int d, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input logic [2:0] pr,
                       output logic [31:0] rd, output logic err,
                       output int cyc);
      logic rdy;
      @(posedge clk); #1;
      psel0 = (d == 0);
      psel3 = (d != 0);
      penable = 1'b0;
      pwrite = wr;
      paddr = a;
      pwdata = wd;
      pstrb = st;
      pprot = pr;
      cyc = 1;
      @(posedge clk); #1;
      penable = 1'b1;
      cyc = 2;
      rdy = (d == 0) ? pready0 : pready3;
      while (!rdy && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         rdy = (d == 0) ? pready0 : pready3;
      end
      tests++;
      if (rdy !== 1'b1) begin
         fails++;
         $display("FAIL xfer_timeout addr=%h: PREADY=%b required 1",
                  a, rdy);
      end
      rd = (d == 0) ? prdata0 : prdata3;
      err = (d == 0) ? pslverr0 : pslverr3;
   endtask

   task automatic bus_idle();
      @(posedge clk); #1;
      psel0 = 1'b0;
      psel3 = 1'b0;
      penable = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (pready0 !== 1'b0) begin
         fails++;
         $display("FAIL reset_pready0: got %b required 0", pready0);
      end
      tests++;
      if (pslverr0 !== 1'b0) begin
         fails++;
         $display("FAIL reset_pslverr0: got %b required 0", pslverr0);
      end
      tests++;
      if (prdata0 !== 32'h0) begin
         fails++;
         $display("FAIL reset_prdata0: got %h required 0", prdata0);
      end
      tests++;
      if (pready3 !== 1'b0) begin
         fails++;
         $display("FAIL reset_pready3: got %b required 0", pready3);
      end
   endtask

   task automatic test_basic();
      logic [31:0] rd;
      logic err;
      int cyc;
      xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, rd, err, cyc);
      tests++;
      if (err !== 1'b0 || cyc != 2) begin
         fails++;
         $display("FAIL basic_write: err=%b cyc=%0d required 0/2",
                  err, cyc);
      end
      xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, err, cyc);
      tests++;
      if (rd !== 32'hDEADBEEF) begin
         fails++;
         $display("FAIL basic_read: got %h required deadbeef", rd);
      end
      tests++;
      if (err !== 1'b0 || cyc != 2) begin
         fails++;
         $display("FAIL basic_read_timing: err=%b cyc=%0d required 0/2",
                  err, cyc);
      end
      bus_idle();
   endtask

   task automatic test_wait();
      logic [31:0] rd;
      logic err;
      int cyc;
      xfer(3, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000, rd, err, cyc);
      tests++;
      if (rd !== 32'h8 || err !== 1'b0) begin
         fails++;
         $display("FAIL wait_read: got %h err=%b required 8/0", rd, err);
      end
      tests++;
      if (cyc != 5) begin
         fails++;
         $display("FAIL wait_cycles: got %0d required 5", cyc);
      end
      bus_idle();
   endtask

   task automatic test_strobe();
      logic [31:0] rd;
      logic err;
      int cyc;
      xfer(3, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, 3'b000, rd, err, cyc);
      xfer(3, 1'b0, 32'h10, 32'h0, 4'hF, 3'b000, rd, err, cyc);
      tests++;
      if (rd !== 32'h00BB00DD) begin
         fails++;
         $display("FAIL strobe_merge: got %h required 00bb00dd", rd);
      end
      xfer(3, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 3'b000, rd, err, cyc);
      tests++;
      if (err !== 1'b0) begin
         fails++;
         $display("FAIL strobe_zero_err: got %b required 0", err);
      end
      xfer(3, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, err, cyc);
      tests++;
      if (rd !== 32'h00BB00DD) begin
         fails++;
         $display("FAIL strobe_zero_noop: got %h required 00bb00dd", rd);
      end
      bus_idle();
   endtask

   task automatic test_errors();
      logic [31:0] rd;
      logic [31:0] xv;
      logic err;
      int cyc;
      xfer(0, 1'b0, 32'h1000, 32'h0, 4'h0, 3'b000, rd, err, cyc);
      tests++;
      if (err !== 1'b1 || rd !== 32'h0) begin
         fails++;
         $display("FAIL err_range: err=%b rd=%h required 1/0", err, rd);
      end
      xfer(0, 1'b1, 32'h12, 32'h55, 4'hF, 3'b000, rd, err, cyc);
      tests++;
      if (err !== 1'b1) begin
         fails++;
         $display("FAIL err_align: got %b required 1", err);
      end
      xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, err, cyc);
      tests++;
      if (rd !== 32'hDEADBEEF || err !== 1'b0) begin
         fails++;
         $display("FAIL err_align_mem: got %h err=%b required deadbeef/0",
                  rd, err);
      end
      xfer(0, 1'b0, 32'hFFC, 32'h0, 4'h0, 3'b000, rd, err, cyc);
      tests++;
      if (rd !== 32'h3FF || err !== 1'b0) begin
         fails++;
         $display("FAIL last_word: got %h err=%b required 3ff/0", rd, err);
      end
      xv = 'x;
      if ($isunknown(xv)) begin
         xfer(0, 1'b1, 32'h20, {28'h0, 4'bx101}, 4'hF, 3'b000,
              rd, err, cyc);
         tests++;
         if (err !== 1'b1) begin
            fails++;
            $display("FAIL err_xdata: got %b required 1", err);
         end
         xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000, rd, err, cyc);
         tests++;
         if (rd !== 32'h8) begin
            fails++;
            $display("FAIL err_xdata_mem: got %h required 8", rd);
         end
      end
      bus_idle();
   endtask

   task automatic test_prot();
      logic [31:0] rd;
      logic err;
      int cyc;
      xfer(0, 1'b1, 32'h0, 32'h11, 4'hF, 3'b010, rd, err, cyc);
      tests++;
      if (err !== PROT_EN) begin
         fails++;
         $display("FAIL prot_nsec_write: got %b required %b", err, PROT_EN);
      end
      xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, err, cyc);
      tests++;
      if (rd !== (PROT_EN ? 32'h0 : 32'h11)) begin
         fails++;
         $display("FAIL prot_nsec_mem: got %h required %h", rd,
                  PROT_EN ? 32'h0 : 32'h11);
      end
      xfer(0, 1'b1, 32'h0, 32'h22, 4'hF, 3'b000, rd, err, cyc);
      tests++;
      if (err !== 1'b0) begin
         fails++;
         $display("FAIL prot_sec_write: got %b required 0", err);
      end
      xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, err, cyc);
      tests++;
      if (rd !== 32'h22) begin
         fails++;
         $display("FAIL prot_sec_mem: got %h required 22", rd);
      end
      bus_idle();
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      logic err;
      int cyc, t0, t1;
      xfer(0, 1'b1, 32'h40, 32'h12345678, 4'hF, 3'b000, rd, err, cyc);
      t0 = cyc_cnt;
      xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, 3'b000, rd, err, cyc);
      t1 = cyc_cnt;
      tests++;
      if (rd !== 32'h12345678) begin
         fails++;
         $display("FAIL b2b_read: got %h required 12345678", rd);
      end
      xfer(0, 1'b0, 32'h44, 32'h0, 4'h0, 3'b000, rd, err, cyc);
      tests++;
      if (rd !== 32'h11) begin
         fails++;
         $display("FAIL b2b_read2: got %h required 11", rd);
      end
      tests++;
      if (t1 - t0 != 2) begin
         fails++;
         $display("FAIL b2b_spacing: got %0d cycles required 2", t1 - t0);
      end
      bus_idle();
   endtask

   task automatic test_abort_psel();
      logic [31:0] rd;
      logic err;
      logic bad;
      int cyc;
      @(posedge clk); #1;
      psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 32'h30; pwdata = 32'hCAFE0000; pstrb = 4'hF; pprot = 3'b000;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      psel3 = 1'b0; penable = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (pready3 !== 1'b0 || pslverr3 !== 1'b0 || prdata3 !== '0)
            bad = 1'b1;
      end
      tests++;
      if (bad !== 1'b0) begin
         fails++;
         $display("FAIL abort_outputs: got %b required 0", bad);
      end
      xfer(3, 1'b0, 32'h30, 32'h0, 4'h0, 3'b000, rd, err, cyc);
      tests++;
      if (rd !== 32'hC || cyc != 5) begin
         fails++;
         $display("FAIL abort_mem: got %h cyc=%0d required c/5", rd, cyc);
      end
      bus_idle();
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      logic err;
      int cyc;
      @(posedge clk); #1;
      psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 32'h34; pwdata = 32'h00000BAD; pstrb = 4'hF; pprot = 3'b000;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      tests++;
      if (pready3 !== 1'b0 || pslverr3 !== 1'b0 || prdata3 !== '0) begin
         fails++;
         $display("FAIL rstmid_outputs: rdy=%b err=%b rd=%h required 0",
                  pready3, pslverr3, prdata3);
      end
      psel3 = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      xfer(3, 1'b0, 32'h34, 32'h0, 4'h0, 3'b000, rd, err, cyc);
      tests++;
      if (rd !== 32'hD || err !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_mem: got %h err=%b required d/0", rd, err);
      end
      xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, err, cyc);
      tests++;
      if (rd !== 32'hDEADBEEF) begin
         fails++;
         $display("FAIL rstmid_mem_kept: got %h required deadbeef", rd);
      end
      bus_idle();
   endtask

   initial begin
      psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
      rst_n = 1'b0;
      test_reset();
      test_basic();
      test_wait();
      test_strobe();
      test_errors();
      test_prot();
      test_back_to_back();
      test_abort_psel();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
